cpx_accumulate: RTL
===================

Name: cpx_accumulate

Overview:
- Downstream stage of the complex multiplier in the CAF datapath.
- Consumes the multiplier's I/Q product stream and integrates `length` consecutive products into one complex sum (one correlation lag / bin).
- Presents each sum on a registered output with a valid/ready handshake.
- Accumulation of the next block overlaps with the wait for the current result to be taken.

Parameters:
- i_bits, 24, width of signed input I sample (matches multiplier i output)
- q_bits, 24, width of signed input Q sample (matches multiplier q output)
- acc_i_bits, 32, width of I accumulator and I output; must be >= i_bits + ceil(log2(length))
- acc_q_bits, 32, width of Q accumulator and Q output; must be >= q_bits + ceil(log2(length))
- length, 256, samples per integration, >= 1
- cnt_bits, 8, counter width; must satisfy 2^cnt_bits >= length

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- m_axis_tvalid  input  1  upstream sample valid
- m_axis_tready  input  1  downstream ready to take the result
- i  input  i_bits  signed I product sample
- q  input  q_bits  signed Q product sample
- s_axis_tready  output  1  block can accept a sample this cycle
- s_axis_tvalid  output  1  acc_i/acc_q hold a completed sum
- acc_i  output  acc_i_bits  signed I sum
- acc_q  output  acc_q_bits  signed Q sum
- sample_cnt  output  cnt_bits  samples accumulated in the current block

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- State at and after reset:
  - Reset clears sum_i, sum_q, sample_cnt, acc_i, acc_q and s_axis_tvalid to 0.
  - s_axis_tready is 0 while reset is high.
  - Reset mid-block discards the partial sum and any held result without emitting it.
- Accept condition: a sample is accepted on a rising edge where m_axis_tvalid & s_axis_tready.
- Accepted sample, not final (sample_cnt != length-1):
  - sum_i <= sum_i + sign_ext(i); sum_q <= sum_q + sign_ext(q).
  - sample_cnt <= sample_cnt + 1.
- Accepted final sample (sample_cnt == length-1):
  - acc_i <= sum_i + sign_ext(i); acc_q <= sum_q + sign_ext(q).
  - s_axis_tvalid <= 1.
  - sum_i, sum_q and sample_cnt <= 0; the next sample starts a fresh block with no gap cycle.
- Latency: the result is visible on acc_i/acc_q with s_axis_tvalid = 1 exactly 1 cycle after the final sample is accepted.
- Output handshake:
  - s_axis_tvalid & m_axis_tready at a rising edge transfers the result; s_axis_tvalid <= 0 unless a new final sample is accepted on that same edge.
  - acc_i and acc_q are held stable while s_axis_tvalid = 1 and m_axis_tready = 0.
- Back-pressure:
  - s_axis_tready = ~reset & ~(sample_cnt == length-1 & s_axis_tvalid).
  - This is decoded from registered state only; there is no combinational path from m_axis_tready or m_axis_tvalid to s_axis_tready.
  - Non-final samples are always accepted while a result is held.
  - Accepting the final sample of block N+1 is blocked until result N has been taken.
- Simultaneous events:
  - If result N is transferred on the same edge that ready is asserted, no collision occurs: ready was decoded the cycle before, so a final sample cannot be accepted while a result is still held.
  - Results are never overwritten or dropped.
- Arithmetic:
  - Inputs are sign-extended to the accumulator width and summed in two's complement.
  - Overflow wraps; correct sizing is the integrator's responsibility via the acc_*_bits constraints.
- length == 1:
  - Every accepted sample is final and appears on acc_* 1 cycle later.
  - s_axis_tready = ~s_axis_tvalid (decoded from registered state), so throughput is at most 1 sample per 2 cycles.
- Gaps: m_axis_tvalid gaps leave sum and count unchanged.

Test Plan:
- Reset then length=4, feed i,q = (1,-1),(2,-2),(3,-3),(4,-4) back-to-back with m_axis_tready=1 -> acc_i=10, acc_q=-10, s_axis_tvalid high for exactly 1 cycle, 1 cycle after the 4th accept; sample_cnt reads 0 afterwards.
- length=4, i = -2^23 on 4 samples with i_bits=24, acc_i_bits=26 -> acc_i = -2^25 exactly, no wrap. Repeat with acc_i_bits=25 -> wraps to 0.
- length=4, m_axis_tready=0 after first result, continuous input:
  - s_axis_tready drops once sample_cnt==3 and stays low.
  - acc_i/acc_q are held unchanged.
  - Raise m_axis_tready -> result 1 is taken, the 8th sample is accepted the next cycle, result 2 follows 1 cycle later.
- Random m_axis_tvalid gaps (50%) with m_axis_tready=1, 3 blocks of length=256 with random 24-bit I/Q -> all three sums match the reference model; no sample is lost or double-counted.
- Assert reset for 1 cycle at sample_cnt=2 mid-block -> s_axis_tvalid=0, sums 0. Then 4 samples of (5,5) -> acc_i=acc_q=20.
- length=1, stream (7,-3),(1,1) with m_axis_tready=1 -> outputs (7,-3) then (1,1); s_axis_tready toggles, throughput is 1 sample per 2 cycles.

Source files
------------

// File: rtl/cpx_accumulate.sv
// cpx_accumulate: integrates `length` consecutive complex products into one
// complex sum and presents it on a registered output with valid/ready.
// Accumulation of the next block overlaps with the wait for the held result.
//
// Handshake semantics: on the input side a sample transfers on a rising edge
// where m_axis_tvalid & s_axis_tready; on the output side a result transfers
// on a rising edge where s_axis_tvalid & m_axis_tready. Once s_axis_tvalid is
// high, acc_i/acc_q are held unchanged until that transfer happens.
module cpx_accumulate #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int acc_i_bits = 32,
    parameter int acc_q_bits = 32,
    parameter int length     = 256,
    parameter int cnt_bits   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic signed [i_bits-1:0]     i,
    input  logic signed [q_bits-1:0]     q,
    output logic                         s_axis_tready,
    output logic                         s_axis_tvalid,
    output logic signed [acc_i_bits-1:0] acc_i,
    output logic signed [acc_q_bits-1:0] acc_q,
    output logic [cnt_bits-1:0]          sample_cnt
);

    // Count value at which the next accepted sample closes the block.
    localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(length - 1);

    logic signed [acc_i_bits-1:0] sum_i;
    logic signed [acc_q_bits-1:0] sum_q;
    logic signed [acc_i_bits-1:0] ext_i;
    logic signed [acc_q_bits-1:0] ext_q;
    logic                         at_last;
    logic                         accept;
    logic                         accept_final;

    // Sign extension: a size cast of a signed operand replicates the sign bit.
    assign ext_i = acc_i_bits'(i);
    assign ext_q = acc_q_bits'(q);

    assign at_last = (sample_cnt == last_cnt);

    // Ready depends only on registered state (and reset): the final sample of
    // a block is held off while the previous result is still waiting, so a
    // held result can never be overwritten. Non-final samples always flow.
    assign s_axis_tready = ~reset & ~(at_last & s_axis_tvalid);

    assign accept       = m_axis_tvalid & s_axis_tready;
    assign accept_final = accept & at_last;

    // Running sums and sample counter; the final sample restarts the block
    // so the next sample begins a fresh sum with no gap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_i      <= '0;
            sum_q      <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            if (at_last) begin
                sum_i      <= '0;
                sum_q      <= '0;
                sample_cnt <= '0;
            end else begin
                sum_i      <= sum_i + ext_i;
                sum_q      <= sum_q + ext_q;
                sample_cnt <= sample_cnt + cnt_bits'(1);
            end
        end
    end

    // Output register: loads the completed sum one cycle after the final
    // accept and holds it until the downstream side takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i         <= '0;
            acc_q         <= '0;
            s_axis_tvalid <= 1'b0;
        end else if (accept_final) begin
            acc_i         <= sum_i + ext_i;
            acc_q         <= sum_q + ext_q;
            s_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            s_axis_tvalid <= 1'b0;
        end
    end

endmodule
